// File: rtl/hdc_pkg.sv
// Shared types and helpers for the HDC Hamming distance engine.
package hdc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SEARCH
  } hd_state_t;

  // Index width that never collapses to zero bits, so a single entry still gets a 1-bit index.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/hamming_chunk_popcount.sv
// Combinational popcount of the masked XOR of two CHUNK-bit slices.
module hamming_chunk_popcount #(
  parameter int unsigned CHUNK = 100,
  parameter int unsigned OUT_W = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [CHUNK-1:0] mask,
  output logic [OUT_W-1:0] count
);

  logic [CHUNK-1:0] diff;

  assign diff = (a ^ b) & mask;

  // Count the differing bits that fall inside the valid region.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      count = count + OUT_W'(diff[i]);
    end
  end

endmodule

// File: rtl/hamming_distance_engine.sv
// Multi-class chunked Hamming distance engine.
// Optional feature macro: HD_ARGMIN_EN adds a sequential arg-min stage (SEARCH state)
// and the best_class / best_dist ports.
module hamming_distance_engine
  import hdc_pkg::*;
#(
  parameter int unsigned N           = 10000,
  parameter int unsigned CHUNK       = 100,
  parameter int unsigned NUM_CLASSES = 21,
  parameter int unsigned DIST_W      = $clog2(N + 1),
  parameter int unsigned CLS_W       = clog2_min1(NUM_CLASSES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N-1:0]                  query_vec,
  input  logic [NUM_CLASSES*N-1:0]      class_vecs,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_CLASSES*DIST_W-1:0] distances
`ifdef HD_ARGMIN_EN
  ,
  output logic [CLS_W-1:0]              best_class,
  output logic [DIST_W-1:0]             best_dist
`endif
);

  localparam int unsigned NUM_CHUNKS = (N + CHUNK - 1) / CHUNK;
  // Vectors are zero-padded to a whole number of chunks so every slice stays in range.
  localparam int unsigned PAD    = NUM_CHUNKS * CHUNK;
  localparam int unsigned CIDX_W = clog2_min1(NUM_CHUNKS);
  localparam int unsigned PC_W   = $clog2(CHUNK + 1);

  hd_state_t state_q, state_d;
  logic      done_q, done_d;
  logic [CIDX_W-1:0] chunk_idx_q;
  logic [DIST_W-1:0] dist_q [NUM_CLASSES];
  logic [PC_W-1:0]   pc     [NUM_CLASSES];

  logic              last_chunk;
  int unsigned       chunk_base;
  logic [PAD-1:0]    q_pad;
  logic [CHUNK-1:0]  q_slice;
  logic [CHUNK-1:0]  valid_mask;

  assign last_chunk = (chunk_idx_q == CIDX_W'(NUM_CHUNKS - 1));
  assign chunk_base = int'(chunk_idx_q) * CHUNK;
  assign q_pad      = PAD'(query_vec);
  assign q_slice    = q_pad[chunk_base +: CHUNK];

  // Bits at or beyond N in the final chunk must contribute nothing.
  always_comb begin
    valid_mask = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      valid_mask[i] = ((chunk_base + i) < N);
    end
  end

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
    logic [PAD-1:0]   c_pad;
    logic [CHUNK-1:0] c_slice;

    assign c_pad   = PAD'(class_vecs[c*N +: N]);
    assign c_slice = c_pad[chunk_base +: CHUNK];

    hamming_chunk_popcount #(
      .CHUNK (CHUNK),
      .OUT_W (PC_W)
    ) u_pc (
      .a     (q_slice),
      .b     (c_slice),
      .mask  (valid_mask),
      .count (pc[c])
    );
  end

`ifdef HD_ARGMIN_EN
  logic [CLS_W-1:0]  srch_idx_q;
  logic [CLS_W-1:0]  best_class_q;
  logic [DIST_W-1:0] best_dist_q;
  logic [DIST_W-1:0] sel_dist;
  logic              last_cls;

  assign last_cls = (srch_idx_q == CLS_W'(NUM_CLASSES - 1));

  // Select the distance of the class currently under search.
  always_comb begin
    sel_dist = '0;
    for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
      if (srch_idx_q == CLS_W'(c)) sel_dist = dist_q[c];
    end
  end
`endif

  // State register plus the one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; done is raised on the edge that returns to IDLE.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ACCUM;
      end
      ACCUM: begin
        if (last_chunk) begin
`ifdef HD_ARGMIN_EN
          state_d = SEARCH;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
      SEARCH: begin
`ifdef HD_ARGMIN_EN
        if (last_cls) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs driven from state and result registers.
  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    distances = '0;
    for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
      distances[c*DIST_W +: DIST_W] = dist_q[c];
    end
`ifdef HD_ARGMIN_EN
    best_class = best_class_q;
    best_dist  = best_dist_q;
`endif
  end

  // Datapath: clear on accepted start, accumulate per chunk, then running arg-min.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chunk_idx_q <= '0;
      for (int unsigned c = 0; c < NUM_CLASSES; c++) dist_q[c] <= '0;
`ifdef HD_ARGMIN_EN
      srch_idx_q   <= '0;
      best_class_q <= '0;
      best_dist_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            chunk_idx_q <= '0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++) dist_q[c] <= '0;
`ifdef HD_ARGMIN_EN
            srch_idx_q   <= '0;
            best_class_q <= '0;
            best_dist_q  <= '0;
`endif
          end
        end
        ACCUM: begin
          for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
            dist_q[c] <= dist_q[c] + DIST_W'(pc[c]);
          end
          chunk_idx_q <= last_chunk ? '0 : chunk_idx_q + CIDX_W'(1);
        end
`ifdef HD_ARGMIN_EN
        SEARCH: begin
          // Strict less-than keeps the lowest index on ties; class 0 always seeds the minimum.
          if ((srch_idx_q == '0) || (sel_dist < best_dist_q)) begin
            best_dist_q  <= sel_dist;
            best_class_q <= srch_idx_q;
          end
          srch_idx_q <= last_cls ? '0 : srch_idx_q + CLS_W'(1);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
